// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: master indices and data-memory geometry shared by the arbiter slice
package ram_arbiter_pkg;
    localparam int RAM_DW = 32;
    localparam int RAM_AW = 12;
    localparam logic M_LSU = 1'b0;
    localparam logic M_DBG = 1'b1;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; force_en hands the channel to a lock owner
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       force_en,
    input  logic       own,
    output logic [1:0] gnt
);
    logic prio;
    always_comb gnt = force_en ? (req & (own ? 2'b10 : 2'b01)) : (&req) ? (prio ? 2'b10 : 2'b01) : req;
    // the winner is prio, so flipping hands priority to the loser
    always_ff @(posedge clk or negedge rst)
        if (!rst) prio <= 1'b0;
        else if (!force_en && &req) prio <= ~prio;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one dual_ram between the LSU and debug port with independent
// round-robin read/write channels and a lock for atomic read-modify-write sequences
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_ren,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);
    logic       lock_q, lock_own_q, rd_pend_q, rd_tag_q, own_lock;
    logic [1:0] wgnt, rgnt, acq;

    rr_arb2 u_wr (.clk(clk), .rst(rst), .req({m1_req & m1_we, m0_req & m0_we}),
                  .force_en(lock_q), .own(lock_own_q), .gnt(wgnt));
    rr_arb2 u_rd (.clk(clk), .rst(rst), .req({m1_req & ~m1_we, m0_req & ~m0_we}),
                  .force_en(lock_q), .own(lock_own_q), .gnt(rgnt));

    always_comb begin
        m0_gnt     = wgnt[M_LSU] | rgnt[M_LSU];
        m1_gnt     = wgnt[M_DBG] | rgnt[M_DBG];
        ram_wen    = |wgnt;
        ram_w_addr = wgnt[M_DBG] ? m1_addr : wgnt[M_LSU] ? m0_addr : '0;
        ram_w_data = wgnt[M_DBG] ? m1_wdata : wgnt[M_LSU] ? m0_wdata : '0;
        ram_ren    = |rgnt;
        ram_r_addr = rgnt[M_DBG] ? m1_addr : rgnt[M_LSU] ? m0_addr : '0;
        m0_rvalid  = rd_pend_q & (rd_tag_q == M_LSU);
        m1_rvalid  = rd_pend_q & (rd_tag_q == M_DBG);
        m0_rdata   = ram_r_data;
        m1_rdata   = ram_r_data;
        acq        = {m1_gnt & m1_lock, m0_gnt & m0_lock};
        own_lock   = (lock_own_q == M_DBG) ? m1_lock : m0_lock;
    end

    // simultaneous acquisition on different channels resolves to the LSU
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            lock_q     <= 1'b0;
            lock_own_q <= M_LSU;
            rd_pend_q  <= 1'b0;
            rd_tag_q   <= M_LSU;
        end else begin
            rd_pend_q <= |rgnt;
            rd_tag_q  <= rgnt[M_DBG] ? M_DBG : M_LSU;
            if (!lock_q) begin
                if (|acq) begin
                    lock_q     <= 1'b1;
                    lock_own_q <= acq[M_LSU] ? M_LSU : M_DBG;
                end
            end else if (!own_lock) lock_q <= 1'b0;
        end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural dual_ram
module tb_ram_arbiter;
    logic        clk = 0, rst = 0;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [11:0] m0_addr = 0, m1_addr = 0;
    logic [31:0] m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wen, ram_ren;
    logic [31:0] m0_rdata, m1_rdata, ram_w_data, ram_r_data;
    logic [11:0] ram_w_addr, ram_r_addr;
    logic [31:0] mem [0:4095];
    int total = 0, bad = 0;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    // write-first dual-port RAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_wen) mem[ram_w_addr] <= ram_w_data;
        if (ram_ren) ram_r_data <= (ram_wen && ram_w_addr == ram_r_addr) ? ram_w_data : mem[ram_r_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_lock = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
    endtask

    task automatic drv(input logic m, input logic we, input logic [11:0] a, input logic [31:0] d, input logic lk);
        if (!m) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lk; end
        else    begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk; end
    endtask

    initial begin
        #12;
        chk("rst_rv0", 32'(m0_rvalid), 0);
        chk("rst_rv1", 32'(m1_rvalid), 0);
        chk("rst_wen", 32'(ram_wen), 0);
        @(negedge clk); rst = 1;
        cyc();

        // solo write then read
        drv(0, 1, 12'h010, 32'hDEADBEEF, 0); #1;
        chk("solo_wgnt", 32'(m0_gnt), 1);
        chk("solo_wen", 32'(ram_wen), 1);
        chk("solo_waddr", 32'(ram_w_addr), 32'h010);
        chk("solo_wdata", ram_w_data, 32'hDEADBEEF);
        chk("solo_m1gnt", 32'(m1_gnt), 0);
        cyc();
        drv(0, 0, 12'h010, 0, 0); #1;
        chk("solo_rgnt", 32'(m0_gnt), 1);
        chk("solo_raddr", 32'(ram_r_addr), 32'h010);
        chk("solo_rv_early", 32'(m0_rvalid), 0);
        cyc(); idle();
        chk("solo_rv", 32'(m0_rvalid), 1);
        chk("solo_rdata", m0_rdata, 32'hDEADBEEF);
        chk("solo_rv1", 32'(m1_rvalid), 0);
        cyc();
        chk("solo_rv_drop", 32'(m0_rvalid), 0);

        // independent channels in one cycle
        drv(0, 0, 12'h020, 0, 0); drv(1, 1, 12'h030, 32'h12345678, 0); #1;
        chk("par_g0", 32'(m0_gnt), 1);
        chk("par_g1", 32'(m1_gnt), 1);
        chk("par_en", {30'd0, ram_wen, ram_ren}, 3);
        chk("par_waddr", 32'(ram_w_addr), 32'h030);
        chk("par_raddr", 32'(ram_r_addr), 32'h020);
        cyc(); idle();
        chk("par_rv0", 32'(m0_rvalid), 1);
        chk("par_rv1", 32'(m1_rvalid), 0);
        drv(0, 0, 12'h030, 0, 0);
        cyc(); idle();
        chk("par_rdback", m0_rdata, 32'h12345678);

        // contended reads alternate starting with m0
        for (int k = 0; k < 6; k++) begin
            drv(0, 0, 12'h010, 0, 0); drv(1, 0, 12'h030, 0, 0); #1;
            chk($sformatf("rr_g0_%0d", k), 32'(m0_gnt), 32'(k % 2 == 0));
            chk($sformatf("rr_g1_%0d", k), 32'(m1_gnt), 32'(k % 2 == 1));
            cyc();
            chk($sformatf("rr_rv0_%0d", k), 32'(m0_rvalid), 32'(k % 2 == 0));
            chk($sformatf("rr_rv1_%0d", k), 32'(m1_rvalid), 32'(k % 2 == 1));
            chk($sformatf("rr_rd_%0d", k), k % 2 ? m1_rdata : m0_rdata, k % 2 ? 32'h12345678 : 32'hDEADBEEF);
        end
        idle();

        // m1 locks for a read-modify-write while m0 keeps asking
        drv(1, 0, 12'h040, 0, 1); #1;
        chk("lk_a_g1", 32'(m1_gnt), 1);
        cyc();
        drv(1, 1, 12'h040, 32'hCAFEF00D, 1); drv(0, 0, 12'h040, 0, 0); #1;
        chk("lk_b_g0", 32'(m0_gnt), 0);
        chk("lk_b_g1", 32'(m1_gnt), 1);
        chk("lk_b_rv1", 32'(m1_rvalid), 1);
        cyc();
        m1_req = 0; m1_lock = 0; #1;
        chk("lk_c_g0", 32'(m0_gnt), 0);
        cyc(); #1;
        chk("lk_d_g0", 32'(m0_gnt), 1);
        cyc(); idle();
        chk("lk_rv0", 32'(m0_rvalid), 1);
        chk("lk_rdata", m0_rdata, 32'hCAFEF00D);

        // same-address write and read in one cycle
        drv(0, 1, 12'h050, 32'hA5A5A5A5, 0); drv(1, 0, 12'h050, 0, 0); #1;
        chk("col_g", {30'd0, m1_gnt, m0_gnt}, 3);
        cyc(); idle();
        chk("col_rv1", 32'(m1_rvalid), 1);
        chk("col_rdata", m1_rdata, 32'hA5A5A5A5);

        // contended read leaves read priority on m1 ahead of the reset test
        drv(0, 0, 12'h050, 0, 0); drv(1, 0, 12'h050, 0, 0); #1;
        chk("pre_g0", 32'(m0_gnt), 1);
        cyc(); idle();
        drv(1, 0, 12'h010, 0, 1);
        cyc();
        drv(1, 0, 12'h010, 0, 1); #1;
        chk("rs_g1", 32'(m1_gnt), 1);
        @(negedge clk); rst = 0;
        cyc();
        chk("rs_rv0", 32'(m0_rvalid), 0);
        chk("rs_rv1", 32'(m1_rvalid), 0);
        cyc();
        chk("rs_rv1b", 32'(m1_rvalid), 0);
        @(negedge clk); rst = 1;
        drv(0, 0, 12'h010, 0, 0); drv(1, 0, 12'h030, 0, 1); #1;
        chk("rs_g0", 32'(m0_gnt), 1);
        chk("rs_g1b", 32'(m1_gnt), 0);
        cyc(); idle();
        chk("rs_rv0b", 32'(m0_rvalid), 1);
        chk("rs_rdata", m0_rdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
